axil_latency_ram: RTL and testbench

//  Parametrised AXI4-Lite slave memory, the bench/SoC successor of the fixed single-port ram model behind the Cpu code/data/mmio buses.

---
 rtl/axil_latency_ram.sv | 237 +++++++++++++++++++++++
 tb/tb_axil_latency_ram.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_latency_ram.sv
// AXI4-Lite slave memory with programmable read/write wait states and SLVERR on
// out-of-range accesses. Independent read and write channels, one outstanding each.
module axil_latency_ram #(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter int unsigned           DEPTH         = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int unsigned           READ_LATENCY  = 0,
  parameter int unsigned           WRITE_LATENCY = 0,
  parameter string                 INIT_FILE     = "",
  localparam int unsigned          STRB_W        = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [2:0]            aw_prot,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [STRB_W-1:0]     w_strb,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [1:0]            b_resp,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [2:0]            ar_prot,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp
);

  localparam int unsigned SHIFT = $clog2(STRB_W);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                  aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic [3:0]            w_cnt_q, w_cnt_d;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic                  mem_we;

  r_state_e              r_state_q, r_state_d;
  logic                  ar_ready_q, ar_ready_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic                  r_valid_q, r_valid_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  // Address decode on the latched addresses; byte-offset bits are dropped.
  logic [ADDR_WIDTH-1:0] w_off, r_off;
  logic                  w_in_range, r_in_range;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  unused_bits;

  assign w_off      = aw_addr_q - BASE_ADDR;
  assign r_off      = ar_addr_q - BASE_ADDR;
  assign w_in_range = (aw_addr_q >= BASE_ADDR) && (w_off[ADDR_WIDTH-1:SHIFT+IDX_W] == '0);
  assign r_in_range = (ar_addr_q >= BASE_ADDR) && (r_off[ADDR_WIDTH-1:SHIFT+IDX_W] == '0);
  assign w_idx      = w_off[SHIFT +: IDX_W];
  assign r_idx      = r_off[SHIFT +: IDX_W];
  assign unused_bits = ^{aw_prot, ar_prot, w_off[SHIFT-1:0], r_off[SHIFT-1:0]};

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = aw_valid && aw_ready_q;
  assign w_hs  = w_valid && w_ready_q;
  assign ar_hs = ar_valid && ar_ready_q;

  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    w_cnt_d    = w_cnt_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    mem_we     = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_addr_d = aw_addr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = w_data;
          w_strb_d = w_strb;
        end
        aw_ready_d = !aw_held_d;
        w_ready_d  = !w_held_d;
        if (aw_held_d && w_held_d) begin
          w_state_d = WWait;
          w_cnt_d   = 4'(WRITE_LATENCY);
        end
      end
      WWait: begin
        if (w_cnt_q == 4'd0) begin
          mem_we    = w_in_range && !reset;
          b_valid_d = 1'b1;
          b_resp_d  = w_in_range ? RespOkay : RespSlvErr;
          w_state_d = WResp;
        end else begin
          w_cnt_d = w_cnt_q - 4'd1;
        end
      end
      WResp: begin
        if (b_ready) begin
          b_valid_d  = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
          w_state_d  = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_d = ar_ready_q;
    ar_addr_d  = ar_addr_q;
    r_cnt_d    = r_cnt_q;
    r_valid_d  = r_valid_q;
    r_resp_d   = r_resp_q;
    r_data_d   = r_data_q;
    unique case (r_state_q)
      RIdle: begin
        ar_ready_d = !ar_hs;
        if (ar_hs) begin
          ar_addr_d = ar_addr;
          r_cnt_d   = 4'(READ_LATENCY);
          r_state_d = RWait;
        end
      end
      RWait: begin
        if (r_cnt_q == 4'd0) begin
          // Reads the array before a same-edge commit lands: pre-write data.
          r_data_d  = r_in_range ? mem[r_idx] : '0;
          r_resp_d  = r_in_range ? RespOkay : RespSlvErr;
          r_valid_d = 1'b1;
          r_state_d = RResp;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      RResp: begin
        if (r_ready) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          r_state_d  = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q  <= WIdle;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      w_cnt_q    <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= '0;
      r_state_q  <= RIdle;
      ar_ready_q <= 1'b0;
      ar_addr_q  <= '0;
      r_cnt_q    <= '0;
      r_valid_q  <= 1'b0;
      r_resp_q   <= '0;
      r_data_q   <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      w_cnt_q    <= w_cnt_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      ar_addr_q  <= ar_addr_d;
      r_cnt_q    <= r_cnt_d;
      r_valid_q  <= r_valid_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) mem[w_idx][i*8 +: 8] <= w_data_q[i*8 +: 8];
      end
    end
  end

  assign aw_ready = aw_ready_q;
  assign w_ready  = w_ready_q;
  assign b_valid  = b_valid_q;
  assign b_resp   = b_resp_q;
  assign ar_ready = ar_ready_q;
  assign r_valid  = r_valid_q;
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;

endmodule

// File: tb/tb_axil_latency_ram.sv
// Bench for axil_latency_ram: a zero-latency instance at base 0 and a
// latency 5/3 instance at base 0x1000, driven through shared channel tasks.
module tb_axil_latency_ram;

  logic        clock;
  logic        reset;
  logic        aw_valid [2];
  logic        aw_ready [2];
  logic [31:0] aw_addr  [2];
  logic [2:0]  aw_prot  [2];
  logic        w_valid  [2];
  logic        w_ready  [2];
  logic [31:0] w_data   [2];
  logic [3:0]  w_strb   [2];
  logic        b_valid  [2];
  logic        b_ready  [2];
  logic [1:0]  b_resp   [2];
  logic        ar_valid [2];
  logic        ar_ready [2];
  logic [31:0] ar_addr  [2];
  logic [2:0]  ar_prot  [2];
  logic        r_valid  [2];
  logic        r_ready  [2];
  logic [31:0] r_data   [2];
  logic [1:0]  r_resp   [2];

  int n_checks;
  int n_fail;

  axil_latency_ram #(
    .DEPTH(1024), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(0), .WRITE_LATENCY(0)
  ) u_dut0 (
    .clock(clock), .reset(reset),
    .aw_valid(aw_valid[0]), .aw_ready(aw_ready[0]), .aw_addr(aw_addr[0]), .aw_prot(aw_prot[0]),
    .w_valid(w_valid[0]), .w_ready(w_ready[0]), .w_data(w_data[0]), .w_strb(w_strb[0]),
    .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_resp(b_resp[0]),
    .ar_valid(ar_valid[0]), .ar_ready(ar_ready[0]), .ar_addr(ar_addr[0]), .ar_prot(ar_prot[0]),
    .r_valid(r_valid[0]), .r_ready(r_ready[0]), .r_data(r_data[0]), .r_resp(r_resp[0])
  );

  axil_latency_ram #(
    .DEPTH(1024), .BASE_ADDR(32'h0000_1000), .READ_LATENCY(5), .WRITE_LATENCY(3)
  ) u_dut1 (
    .clock(clock), .reset(reset),
    .aw_valid(aw_valid[1]), .aw_ready(aw_ready[1]), .aw_addr(aw_addr[1]), .aw_prot(aw_prot[1]),
    .w_valid(w_valid[1]), .w_ready(w_ready[1]), .w_data(w_data[1]), .w_strb(w_strb[1]),
    .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_resp(b_resp[1]),
    .ar_valid(ar_valid[1]), .ar_ready(ar_ready[1]), .ar_addr(ar_addr[1]), .ar_prot(ar_prot[1]),
    .r_valid(r_valid[1]), .r_ready(r_ready[1]), .r_data(r_data[1]), .r_resp(r_resp[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;
  rexp_t sb_q[$];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wlead;
    logic [1:0]  exp_b;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic [1:0]  exp_r;
  } vec_t;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input int d);
    check($sformatf("reset_outputs_dut%0d", d),
          64'({aw_ready[d], w_ready[d], ar_ready[d], b_valid[d], r_valid[d],
               b_resp[d], r_resp[d], r_data[d]}), 64'd0);
  endtask

  task automatic check_readys(input int d);
    check($sformatf("readys_after_reset_dut%0d", d),
          64'({aw_ready[d], w_ready[d], ar_ready[d]}), 64'b111);
  endtask

  // W is presented w_lead cycles before AW; B is left unacknowledged for b_hold cycles.
  task automatic axi_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_hold,
                           input logic [1:0] exp_resp, input int exp_lat);
    bit aw_done, w_done, hs_aw, hs_w;
    int n, k;
    aw_done = 0;
    w_done  = 0;
    n       = 0;
    w_valid[d] = 1'b1;
    w_data[d]  = data;
    w_strb[d]  = strb;
    while (!(aw_done && w_done) && n < 50) begin
      if (n == w_lead) begin
        aw_valid[d] = 1'b1;
        aw_addr[d]  = addr;
      end
      hs_aw = aw_valid[d] && aw_ready[d];
      hs_w  = w_valid[d] && w_ready[d];
      tick();
      n++;
      if (hs_aw) begin aw_valid[d] = 1'b0; aw_done = 1; end
      if (hs_w)  begin w_valid[d]  = 1'b0; w_done  = 1; end
    end
    aw_valid[d] = 1'b0;
    w_valid[d]  = 1'b0;
    check("aw_w_accepted", 64'({aw_done, w_done}), 64'b11);
    k = 1;
    while (!b_valid[d] && k < 40) begin
      tick();
      k++;
    end
    check("b_latency", 64'(k), 64'(exp_lat));
    for (int i = 0; i < b_hold; i++) begin
      check("b_valid_held", 64'(b_valid[d]), 64'd1);
      check("b_resp_held", 64'(b_resp[d]), 64'(exp_resp));
      tick();
    end
    check("b_resp", 64'(b_resp[d]), 64'(exp_resp));
    b_ready[d] = 1'b1;
    tick();
    b_ready[d] = 1'b0;
    check("b_valid_drop", 64'(b_valid[d]), 64'd0);
  endtask

  task automatic axi_read(input int d, input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int r_hold, input int exp_lat);
    rexp_t e;
    bit    done;
    int    n, k;
    ar_valid[d] = 1'b1;
    ar_addr[d]  = addr;
    sb_q.push_back('{data: exp_data, resp: exp_resp});
    done = 0;
    n    = 0;
    while (!done && n < 50) begin
      done = ar_ready[d];
      tick();
      n++;
    end
    ar_valid[d] = 1'b0;
    check("ar_accepted", 64'(done), 64'd1);
    k = 1;
    while (!r_valid[d] && k < 40) begin
      tick();
      k++;
    end
    check("r_latency", 64'(k), 64'(exp_lat));
    e = sb_q.pop_front();
    for (int i = 0; i < r_hold; i++) begin
      check("r_valid_held", 64'(r_valid[d]), 64'd1);
      check("r_data_held", 64'(r_data[d]), 64'(e.data));
      tick();
    end
    check("r_data", 64'(r_data[d]), 64'(e.data));
    check("r_resp", 64'(r_resp[d]), 64'(e.resp));
    r_ready[d] = 1'b1;
    tick();
    r_ready[d] = 1'b0;
    check("r_valid_drop", 64'(r_valid[d]), 64'd0);
  endtask

  vec_t vecs [7];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      aw_valid[d] = 0; aw_addr[d] = '0; aw_prot[d] = '0;
      w_valid[d]  = 0; w_data[d]  = '0; w_strb[d]  = '0;
      b_ready[d]  = 0;
      ar_valid[d] = 0; ar_addr[d] = '0; ar_prot[d] = '0;
      r_ready[d]  = 0;
    end

    vecs[0] = '{32'h10,   32'hDEADBEEF, 4'b1111, 0, 2'b00, 32'h10,   32'hDEADBEEF, 2'b00};
    vecs[1] = '{32'h30,   32'h11223344, 4'b1111, 0, 2'b00, 32'h30,   32'h11223344, 2'b00};
    vecs[2] = '{32'h30,   32'h0000AB00, 4'b0010, 3, 2'b00, 32'h30,   32'h1122AB44, 2'b00};
    vecs[3] = '{32'h13,   32'hA5A5A5A5, 4'b1111, 0, 2'b00, 32'h10,   32'hA5A5A5A5, 2'b00};
    vecs[4] = '{32'hFFC,  32'h01020304, 4'b1111, 1, 2'b00, 32'hFFE,  32'h01020304, 2'b00};
    vecs[5] = '{32'h1000, 32'h55555555, 4'b1111, 0, 2'b10, 32'h1000, 32'h00000000, 2'b10};
    vecs[6] = '{32'h10,   32'hFF0000EE, 4'b1001, 0, 2'b00, 32'h10,   32'hFFA5A5EE, 2'b00};

    // Reset, then reset again while the slow instance is mid-read.
    repeat (10) tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    reset = 1'b0;
    tick();
    check_readys(0);
    check_readys(1);
    ar_valid[1] = 1'b1;
    ar_addr[1]  = 32'h1000;
    tick();
    ar_valid[1] = 1'b0;
    check("ar_ready_busy", 64'(ar_ready[1]), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    reset = 1'b0;
    tick();
    check_readys(0);
    check_readys(1);

    foreach (vecs[i]) begin
      axi_write(0, vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].wlead, 0,
                vecs[i].exp_b, 2);
      axi_read(0, vecs[i].raddr, vecs[i].exp_rd, vecs[i].exp_r, 0, 2);
    end

    // Slow instance: stalled B/R responses must hold steady.
    axi_write(1, 32'h1010, 32'h12345678, 4'b1111, 0, 4, 2'b00, 5);
    axi_read(1, 32'h1010, 32'h12345678, 2'b00, 4, 7);

    axi_write(1, 32'h1000, 32'hCAFEF00D, 4'b1111, 0, 0, 2'b00, 5);
    axi_write(1, 32'h2000, 32'h11111111, 4'b1111, 0, 0, 2'b10, 5);
    axi_write(1, 32'h0FFC, 32'h22222222, 4'b1111, 0, 0, 2'b10, 5);
    axi_read(1, 32'h2000, 32'h0, 2'b10, 0, 7);
    axi_read(1, 32'h0FFC, 32'h0, 2'b10, 0, 7);
    axi_read(1, 32'h1000, 32'hCAFEF00D, 2'b00, 0, 7);
    axi_write(1, 32'h1FFC, 32'h0BADCAFE, 4'b1111, 0, 0, 2'b00, 5);
    axi_read(1, 32'h1FFC, 32'h0BADCAFE, 2'b00, 0, 7);

    // Commit and read capture on the same edge: read sees the old word.
    axi_write(0, 32'h20, 32'h1, 4'b1111, 0, 0, 2'b00, 2);
    axi_read(0, 32'h20, 32'h1, 2'b00, 0, 2);
    fork
      axi_write(0, 32'h20, 32'h2, 4'b1111, 0, 0, 2'b00, 2);
      axi_read(0, 32'h20, 32'h1, 2'b00, 0, 2);
    join
    axi_read(0, 32'h20, 32'h2, 2'b00, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
